// File: rtl/caf_pkg.sv
// Shared state encoding and default widths for the frequency-bin search controller.
package caf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        STREAM,
        WAIT_RES,
        UPDATE,
        DONE
    } state_t;

    localparam int unsigned BUFFER_LENGTH = 10;
    localparam int unsigned INDEX_BITS    = 4;
    localparam int unsigned OUT_MAX_BITS  = 4;
    localparam int unsigned I_BITS        = 12;
    localparam int unsigned Q_BITS        = 12;
    localparam int unsigned FREQ_BITS     = 6;
    localparam int unsigned SETTLE_CYCLES = 4;

endpackage

// File: rtl/peak_tracker.sv
// Holds the latest per-bin argmax result and the running global peak across bins.
module peak_tracker
    import caf_pkg::*;
#(
    parameter int unsigned index_bits   = INDEX_BITS,
    parameter int unsigned out_max_bits = OUT_MAX_BITS,
    parameter int unsigned freq_bits    = FREQ_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    capture,
    input  logic                    update,
    input  logic [out_max_bits-1:0] cand_max,
    input  logic [index_bits-1:0]   cand_index,
    input  logic [freq_bits-1:0]    bin,
    output logic [out_max_bits-1:0] best_max,
    output logic [index_bits-1:0]   best_index,
    output logic [freq_bits-1:0]    best_bin
);

    logic [out_max_bits-1:0] res_max;
    logic [index_bits-1:0]   res_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_max    <= '0;
            res_index  <= '0;
            best_max   <= '0;
            best_index <= '0;
            best_bin   <= '0;
        end else begin
            if (capture) begin
                res_max   <= cand_max;
                res_index <= cand_index;
            end
            // Strict compare: a tie keeps the earlier bin.
            if (clear) begin
                best_max   <= '0;
                best_index <= '0;
                best_bin   <= '0;
            end else if (update && (res_max > best_max)) begin
                best_max   <= res_max;
                best_index <= res_index;
                best_bin   <= bin;
            end
        end
    end

endmodule

// File: rtl/caf_search_ctrl.sv
// Steps freq_sel across bins, streams one buffer per bin into the argmax engine
// and reports the strongest peak over the whole search.
module caf_search_ctrl
    import caf_pkg::*;
#(
    parameter int unsigned buffer_length = BUFFER_LENGTH,
    parameter int unsigned index_bits    = INDEX_BITS,
    parameter int unsigned out_max_bits  = OUT_MAX_BITS,
    parameter int unsigned i_bits        = I_BITS,
    parameter int unsigned q_bits        = Q_BITS,
    parameter int unsigned freq_bits     = FREQ_BITS,
    parameter int unsigned settle_cycles = SETTLE_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [freq_bits-1:0]    num_bins,
    output logic                    busy,
    output logic [freq_bits-1:0]    freq_sel,
    input  logic                    m_axis_tvalid,
    input  logic signed [i_bits-1:0] xi,
    input  logic signed [q_bits-1:0] xq,
    output logic                    s_axis_tready,
    output logic                    am_tvalid,
    output logic [i_bits-1:0]       am_xi,
    output logic [q_bits-1:0]       am_xq,
    input  logic                    am_tready,
    input  logic                    am_result_valid,
    input  logic [out_max_bits-1:0] am_out_max,
    input  logic [index_bits-1:0]   am_index,
    output logic                    am_result_ready,
    input  logic                    m_axis_tready,
    output logic                    s_axis_tvalid,
    output logic [out_max_bits-1:0] best_max,
    output logic [index_bits-1:0]   best_index,
    output logic [freq_bits-1:0]    best_bin
);

    localparam int unsigned CNT_BITS = $clog2(buffer_length + 1);
    localparam int unsigned SET_BITS = $clog2(settle_cycles + 1);
    localparam logic [CNT_BITS-1:0] LAST_SAMPLE = CNT_BITS'(buffer_length - 1);
    localparam logic [SET_BITS-1:0] LAST_SETTLE = SET_BITS'(settle_cycles - 1);

    state_t               state, state_next;
    logic [freq_bits-1:0] num_bins_q;
    logic [freq_bits-1:0] last_sel;
    logic [CNT_BITS-1:0]  sample_cnt;
    logic [SET_BITS-1:0]  settle_cnt;
    logic                 launch, capture, update, xfer, last_bin;

    assign busy     = (state != IDLE);
    assign last_sel = num_bins_q - 1'b1;
    assign last_bin = (freq_sel == last_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        s_axis_tready   = 1'b0;
        am_tvalid       = 1'b0;
        am_xi           = '0;
        am_xq           = '0;
        am_result_ready = 1'b0;
        s_axis_tvalid   = 1'b0;
        launch          = 1'b0;
        capture         = 1'b0;
        update          = 1'b0;
        xfer            = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && (num_bins != '0)) begin
                    launch     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == LAST_SETTLE) state_next = STREAM;
            end
            STREAM: begin
                am_xi         = xi;
                am_xq         = xq;
                am_tvalid     = m_axis_tvalid;
                s_axis_tready = am_tready;
                xfer          = m_axis_tvalid && am_tready;
                if (xfer && (sample_cnt == LAST_SAMPLE)) state_next = WAIT_RES;
            end
            WAIT_RES: begin
                am_result_ready = 1'b1;
                if (am_result_valid) begin
                    capture    = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                update     = 1'b1;
                state_next = last_bin ? DONE : SETTLE;
            end
            DONE: begin
                s_axis_tvalid = 1'b1;
                if (m_axis_tready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_bins_q <= '0;
            freq_sel   <= '0;
            sample_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            if (launch) begin
                num_bins_q <= num_bins;
                freq_sel   <= '0;
            end else if (update && !last_bin) begin
                freq_sel <= freq_sel + 1'b1;
            end
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            if ((state != STREAM) && (state_next == STREAM)) sample_cnt <= '0;
            else if (xfer)                                   sample_cnt <= sample_cnt + 1'b1;
        end
    end

    peak_tracker #(
        .index_bits  (index_bits),
        .out_max_bits(out_max_bits),
        .freq_bits   (freq_bits)
    ) u_peak (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (launch),
        .capture   (capture),
        .update    (update),
        .cand_max  (am_out_max),
        .cand_index(am_index),
        .bin       (freq_sel),
        .best_max  (best_max),
        .best_index(best_index),
        .best_bin  (best_bin)
    );

endmodule

// File: tb/tb_caf_search_ctrl.sv
// Scoreboard bench: stimulus queues expected peaks, a monitor plays the argmax
// engine and downstream sink and compares every observed output.
module tb_caf_search_ctrl;
    import caf_pkg::*;

    localparam int unsigned BL = 10;
    localparam int unsigned IB = 4;
    localparam int unsigned MB = 4;
    localparam int unsigned XB = 12;
    localparam int unsigned FB = 6;
    localparam int unsigned SC = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [FB-1:0]        num_bins = '0;
    logic                 busy;
    logic [FB-1:0]        freq_sel;
    logic                 m_axis_tvalid = 1'b0;
    logic signed [XB-1:0] xi = '0;
    logic signed [XB-1:0] xq = '0;
    logic                 s_axis_tready;
    logic                 am_tvalid;
    logic [XB-1:0]        am_xi;
    logic [XB-1:0]        am_xq;
    logic                 am_tready = 1'b0;
    logic                 am_result_valid = 1'b0;
    logic [MB-1:0]        am_out_max = '0;
    logic [IB-1:0]        am_index = '0;
    logic                 am_result_ready;
    logic                 m_axis_tready = 1'b0;
    logic                 s_axis_tvalid;
    logic [MB-1:0]        best_max;
    logic [IB-1:0]        best_index;
    logic [FB-1:0]        best_bin;

    caf_search_ctrl #(
        .buffer_length(BL),
        .index_bits   (IB),
        .out_max_bits (MB),
        .i_bits       (XB),
        .q_bits       (XB),
        .freq_bits    (FB),
        .settle_cycles(SC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_bins       (num_bins),
        .busy           (busy),
        .freq_sel       (freq_sel),
        .m_axis_tvalid  (m_axis_tvalid),
        .xi             (xi),
        .xq             (xq),
        .s_axis_tready  (s_axis_tready),
        .am_tvalid      (am_tvalid),
        .am_xi          (am_xi),
        .am_xq          (am_xq),
        .am_tready      (am_tready),
        .am_result_valid(am_result_valid),
        .am_out_max     (am_out_max),
        .am_index       (am_index),
        .am_result_ready(am_result_ready),
        .m_axis_tready  (m_axis_tready),
        .s_axis_tvalid  (s_axis_tvalid),
        .best_max       (best_max),
        .best_index     (best_index),
        .best_bin       (best_bin)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned mx;
        int unsigned idx;
        int unsigned bin;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pk[4];
    int unsigned ix[4];
    bit          gaps = 1'b0;
    int unsigned ready_delay = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected the awaited event (t=%0t)", name, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_freq_sel"}, freq_sel, 0);
        check({tag, "_s_axis_tready"}, s_axis_tready, 0);
        check({tag, "_am_tvalid"}, am_tvalid, 0);
        check({tag, "_am_result_ready"}, am_result_ready, 0);
        check({tag, "_s_axis_tvalid"}, s_axis_tvalid, 0);
        check({tag, "_best_max"}, best_max, 0);
        check({tag, "_best_index"}, best_index, 0);
        check({tag, "_best_bin"}, best_bin, 0);
    endtask

    // Monitor: acts as argmax engine, upstream source and downstream sink.
    initial begin
        int unsigned bin = 0, xfers = 0, settle_left = 0, done_cnt = 0, t0 = 0, nb = 0;
        bit   res_pending = 0, hs_done = 0, check_ready = 0;
        exp_t cur;
        cur = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bin = 0; xfers = 0; settle_left = 0; done_cnt = 0;
                res_pending = 0; hs_done = 0; check_ready = 0;
                m_axis_tvalid = 0; am_tready = 0; am_result_valid = 0; m_axis_tready = 0;
                continue;
            end
            m_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            am_tready     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            xi = XB'($urandom);
            xq = XB'($urandom);
            if (res_pending) begin
                am_result_valid = 1'b1;
                am_out_max      = MB'(pk[bin]);
                am_index        = IB'(ix[bin]);
            end else if (gaps && ($urandom_range(0, 3) == 0)) begin
                am_result_valid = 1'b1;
                am_out_max      = '1;
                am_index        = '1;
            end else begin
                am_result_valid = 1'b0;
            end
            m_axis_tready = s_axis_tvalid && (done_cnt >= ready_delay);
            #1;
            if (hs_done) begin
                check("after_done_tvalid", s_axis_tvalid, 0);
                check("after_done_busy", busy, 0);
                hs_done = 0;
            end
            check("result_ready", am_result_ready, res_pending);
            if (!busy) begin
                check("idle_s_axis_tready", s_axis_tready, 0);
                check("idle_am_tvalid", am_tvalid, 0);
            end
            if (settle_left > 0) begin
                check("settle_s_axis_tready", s_axis_tready, 0);
                check("settle_am_tvalid", am_tvalid, 0);
                settle_left--;
                if (settle_left == 0 && !gaps) check_ready = 1;
            end else if (check_ready) begin
                check("stream_open", s_axis_tready, 1);
                check_ready = 0;
            end
            if (res_pending) check("tready_after_last", s_axis_tready, 0);
            if (s_axis_tready) begin
                check("tready_pass", am_tready, 1);
                check("tvalid_pass", am_tvalid, m_axis_tvalid);
                if (m_axis_tvalid) begin
                    check("am_xi", am_xi, $unsigned(xi));
                    check("am_xq", am_xq, $unsigned(xq));
                    check("bin_order", freq_sel, bin);
                    xfers++;
                    if (xfers == BL) res_pending = 1;
                end
            end
            if (am_result_valid && am_result_ready) begin
                check("xfers_per_bin", xfers, BL);
                res_pending = 0;
                xfers = 0;
                if (bin + 1 < nb) begin
                    bin++;
                    settle_left = SC + 1;
                end
            end
            if (start && !busy && (num_bins != 0)) begin
                nb = num_bins; bin = 0; xfers = 0; res_pending = 0;
                settle_left = SC; t0 = cyc + 1;
            end
            if (s_axis_tvalid) begin
                if (done_cnt == 0) begin
                    if (exp_q.size() == 0) begin
                        fail_timeout("unexpected_result");
                        cur = '{0, 0, 0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (!gaps) check("latency", cyc - t0 + 1, nb * (SC + BL + 2) + 1);
                end
                check("best_max", best_max, cur.mx);
                check("best_index", best_index, cur.idx);
                check("best_bin", best_bin, cur.bin);
                check("done_busy", busy, 1);
                done_cnt++;
                if (m_axis_tready) begin
                    hs_done  = 1;
                    done_cnt = 0;
                end
            end
        end
    end

    task automatic launch(input int unsigned n, input int unsigned mx, input int unsigned idx,
                          input int unsigned bn);
        exp_q.push_back('{mx, idx, bn});
        @(negedge clk);
        start    = 1'b1;
        num_bins = FB'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (k >= 3000) fail_timeout(name);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned k;
        repeat (3) @(negedge clk);
        #2 check_all_zero("reset");
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pk = '{5, 9, 7, 0}; ix = '{2, 4, 1, 0};
        launch(3, 9, 4, 1);
        wait_idle("wait_three_bins");

        pk = '{6, 6, 0, 0}; ix = '{3, 7, 0, 0};
        launch(2, 6, 3, 0);
        wait_idle("wait_tie");

        pk = '{0, 0, 0, 0}; ix = '{5, 0, 0, 0};
        launch(1, 0, 0, 0);
        wait_idle("wait_zero_peak");

        @(negedge clk);
        start = 1'b1; num_bins = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #2;
            check("nbins0_busy", busy, 0);
            check("nbins0_freq_sel", freq_sel, 0);
        end

        gaps = 1'b1; ready_delay = 2;
        pk = '{3, 12, 12, 0}; ix = '{0, 9, 5, 0};
        launch(3, 12, 9, 1);
        repeat (20) @(negedge clk);
        start = 1'b1; num_bins = FB'(1);
        @(negedge clk);
        start = 1'b0;
        wait_idle("wait_gaps");
        gaps = 1'b0; ready_delay = 0;

        pk = '{1, 2, 3, 14}; ix = '{6, 2, 0, 6};
        launch(4, 14, 6, 3);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(freq_sel == 1 && s_axis_tready) && k < 500);
        if (k >= 500) fail_timeout("reach_bin1_stream");
        #1 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #2;
            check("post_reset_busy", busy, 0);
            check("post_reset_freq_sel", freq_sel, 0);
        end

        ready_delay = 20;
        launch(4, 14, 6, 3);
        wait_idle("wait_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation time limit, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/caf_search_ctrl.md
CAF_SEARCH_CTRL -- requirements
Module: caf_search_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - buffer_length, 10, samples per frequency bin passed to the argmax engine
  - index_bits, 4, argmax index width
  - out_max_bits, 4, argmax magnitude width
  - i_bits, 12, I sample width
  - q_bits, 12, Q sample width
  - freq_bits, 6, frequency-bin select width
  - settle_cycles, 4, idle cycles after each freq_sel change
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, single clock
  - rst_n, in, 1, asynchronous active-low reset
  - start, in, 1, begin search pulse
  - num_bins, in, freq_bits, bins to search; sampled on start
  - busy, out, 1, search in progress
  - freq_sel, out, freq_bits, current bin index driven to the mixer/NCO
  - m_axis_tvalid, in, 1, upstream sample valid
  - xi, in signed, i_bits, upstream I sample
  - xq, in signed, q_bits, upstream Q sample
  - s_axis_tready, out, 1, ready to upstream
  - am_tvalid, out, 1, sample valid to argmax
  - am_xi, out, i_bits, I sample to argmax
  - am_xq, out, q_bits, Q sample to argmax
  - am_tready, in, 1, argmax ready
  - am_result_valid, in, 1, argmax result valid
  - am_out_max, in, out_max_bits, argmax peak magnitude
  - am_index, in, index_bits, argmax peak index
  - am_result_ready, out, 1, result accept to argmax
  - m_axis_tready, in, 1, downstream ready for the final result
  - s_axis_tvalid, out, 1, final result valid
  - best_max, out, out_max_bits, global peak magnitude
  - best_index, out, index_bits, sample index of the global peak
  - best_bin, out, freq_bits, bin of the global peak

Function
REQ-003 The FSM SHALL have six states: IDLE, SETTLE, STREAM, WAIT_RES, UPDATE, DONE.
REQ-004 IDLE: start=1 with num_bins!=0 SHALL latch num_bins, clear freq_sel, best_max, best_index and best_bin to 0, and go to SETTLE; start with num_bins=0 SHALL be ignored.
REQ-005 SETTLE SHALL last exactly settle_cycles cycles with s_axis_tready=0 and am_tvalid=0, then go to STREAM.
REQ-006 STREAM: am_xi=xi, am_xq=xq, am_tvalid=m_axis_tvalid and s_axis_tready=am_tready SHALL all be combinational pass-through; one sample is counted per cycle with m_axis_tvalid&&am_tready.
REQ-007 After buffer_length counted samples, STREAM SHALL go to WAIT_RES, and s_axis_tready SHALL be 0 from the cycle after the last transfer.
REQ-008 WAIT_RES SHALL hold am_result_ready=1; am_result_valid=1 SHALL register am_out_max and am_index and go to UPDATE.
REQ-009 UPDATE SHALL load best_max, best_index and best_bin=freq_sel only if am_out_max > best_max (strict, so ties keep the earliest bin).
REQ-010 On leaving UPDATE: if freq_sel==num_bins-1 go to DONE; else increment freq_sel and go to SETTLE.
REQ-011 DONE SHALL hold s_axis_tvalid=1 with best_* stable until m_axis_tready=1, then go to IDLE with s_axis_tvalid=0 the next cycle.
REQ-012 busy SHALL be 1 in every state except IDLE; start while busy=1 SHALL be ignored.
REQ-013 In every state other than STREAM: s_axis_tready=0 and am_tvalid=0; am_result_ready SHALL be 1 only in WAIT_RES.
REQ-014 A result arriving outside WAIT_RES SHALL NOT be accepted.
REQ-015 The sample counter SHALL be ceil(log2(buffer_length+1)) bits wide and clear on entry to STREAM; freq_sel SHALL never exceed num_bins-1.
REQ-016 Minimum search latency from start to s_axis_tvalid, with continuous valid/ready and a 1-cycle result, SHALL be num_bins*(settle_cycles+buffer_length+2)+1 cycles.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE and zero all counters and all outputs (busy, freq_sel, s_axis_tready, am_tvalid, am_result_ready, s_axis_tvalid, best_*), including mid-search.
REQ-018 The block SHALL resume only on a new start after rst_n deasserts.

Structure
REQ-019 The state encoding and default widths SHALL live in shared package caf_pkg.
REQ-020 The comparison/update register SHALL be one sub-module, peak_tracker; there SHALL be no other hierarchy.

Verification
REQ-021 num_bins=3, bin peaks 5, 9, 7 at indices 2, 4, 1: expect s_axis_tvalid with best_max=9, best_index=4, best_bin=1.
REQ-022 Tie: bin peaks 6, 6: expect best_bin=0.
REQ-023 start with num_bins=0: expect busy stays 0 and freq_sel stays 0.
REQ-024 Random m_axis_tvalid/am_tready gaps: expect exactly buffer_length transfers per bin and s_axis_tready=0 during SETTLE.
REQ-025 rst_n pulsed during STREAM of bin 1: expect all outputs 0 immediately and IDLE; the next start restarts from bin 0.
REQ-026 m_axis_tready held low 20 cycles in DONE: expect s_axis_tvalid and best_* stable for all 20 cycles, then IDLE.
